// File: rtl/angle_ctrl_pkg.sv
// Shared constants and FSM state type for the angle seek controller.
package angle_ctrl_pkg;

  localparam int unsigned COUNTS_PER_REV_DEF = 1006;
  localparam int unsigned ANGLE_W            = 12;
  localparam int unsigned DUTY_W             = 8;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    DIV,
    DRIVE,
    SETTLE
  } state_e;

endpackage

// File: rtl/round_div.sv
// Sequential restoring divider, one quotient bit per clock, round-half-up result.
module round_div #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int unsigned      CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(DIVIDEND_W);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] dq_q, dq_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;

  logic                  fits;
  logic [DIVISOR_W-1:0]  rem_nx;
  logic [DIVIDEND_W-1:0] dq_nx;
  logic                  round_up;

  always_comb begin
    fits     = {rem_q, dq_q[DIVIDEND_W-1]} >= {1'b0, dvs_q};
    rem_nx   = fits ? DIVISOR_W'({rem_q, dq_q[DIVIDEND_W-1]} - {1'b0, dvs_q})
                    : DIVISOR_W'({rem_q, dq_q[DIVIDEND_W-1]});
    // dq_q shifts the dividend out at the top while quotient bits enter at the bottom
    dq_nx    = {dq_q[DIVIDEND_W-2:0], fits};
    round_up = {rem_nx, 1'b0} >= {1'b0, dvs_q};

    rem_d  = rem_q;
    dq_d   = dq_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    quot_d = quot_q;

    if (start) begin
      rem_d = '0;
      dq_d  = dividend;
      dvs_d = divisor;
      cnt_d = STEPS;
    end else if (cnt_q != '0) begin
      rem_d = rem_nx;
      dq_d  = dq_nx;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        done_d = 1'b1;
        quot_d = dq_nx + DIVIDEND_W'(round_up);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dq_q   <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      quot_q <= '0;
    end else begin
      rem_q  <= rem_d;
      dq_q   <= dq_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      quot_q <= quot_d;
    end
  end

  assign done     = done_q;
  assign quotient = quot_q;

endmodule

// File: rtl/angle_seek_ctrl.sv
// Shortest-path angle seek: command handshake, distance/direction, duty via
// rounding divider, periodic duty refresh while driving, settle-and-retry.
module angle_seek_ctrl
  import angle_ctrl_pkg::*;
#(
  parameter int unsigned COUNTS_PER_REV = COUNTS_PER_REV_DEF,
  parameter int unsigned TOL            = 2,
  parameter int unsigned MIN_DUTY       = 20,
  parameter int unsigned SETTLE_CYC     = 1000,
  parameter int unsigned UPDATE_CYC     = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ANGLE_W-1:0] cmd_angle,
  input  logic [ANGLE_W-1:0] cur_angle,
  input  logic               abort,
  output logic [DUTY_W-1:0]  pwm_duty,
  output logic               dir,
  output logic               motor_en,
  output logic               busy,
  output logic               done,
  output logic               err_range
);

  localparam int unsigned CNT_W         = 16;
  localparam int unsigned HALF_REV      = COUNTS_PER_REV / 2;
  localparam int unsigned BIAS_Q        = 128;
  localparam int unsigned BIAS_TH_I     = BIAS_Q * HALF_REV;
  localparam int unsigned UPDATE_LAST_I = UPDATE_CYC - 1;
  localparam int unsigned SETTLE_LAST_I = SETTLE_CYC - 1;

  localparam logic [ANGLE_W:0]   CPR_X       = COUNTS_PER_REV[ANGLE_W:0];
  localparam logic [ANGLE_W-1:0] CPR_A       = COUNTS_PER_REV[ANGLE_W-1:0];
  localparam logic [ANGLE_W-1:0] TOL_A       = TOL[ANGLE_W-1:0];
  localparam logic [ANGLE_W-1:0] DIVISOR     = HALF_REV[ANGLE_W-1:0];
  localparam logic [19:0]        BIAS_TH     = BIAS_TH_I[19:0];
  localparam logic [DUTY_W-1:0]  MIN_DUTY_D  = MIN_DUTY[DUTY_W-1:0];
  localparam logic [CNT_W-1:0]   UPDATE_LAST = UPDATE_LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0]   SETTLE_LAST = SETTLE_LAST_I[CNT_W-1:0];

  state_e             state_q, state_d;
  logic [ANGLE_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0]  pwm_q, pwm_d;
  logic               dir_q, dir_d;
  logic               motor_en_q, motor_en_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   upd_cnt_q, upd_cnt_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic               bias_q, bias_d;

  logic [ANGLE_W:0]   diff;
  logic [ANGLE_W-1:0] cw_c, acw_c, dist_c;
  logic               dir_c, near_c;
  logic [19:0]        prod_c, num_c;
  logic               bias_c;
  logic [15:0]        dividend_c;
  logic               div_start, div_done;
  logic [15:0]        div_quot;
  logic [16:0]        duty_raw;
  logic [DUTY_W-1:0]  duty_c;

  always_comb begin
    diff   = {1'b0, target_q} - {1'b0, cur_angle};
    cw_c   = diff[ANGLE_W] ? ANGLE_W'(diff + CPR_X) : diff[ANGLE_W-1:0];
    acw_c  = (cw_c == '0) ? '0 : CPR_A - cw_c;
    dir_c  = (cw_c <= acw_c);
    dist_c = dir_c ? cw_c : acw_c;
    near_c = (dist_c <= TOL_A);

    // dist*255 overflows 16 bits near half a revolution; pulling out 128*divisor
    // keeps the remainder (and so the rounding) intact, and 128 is added back after.
    prod_c     = {8'd0, dist_c} * 20'd255;
    bias_c     = (prod_c >= BIAS_TH);
    num_c      = bias_c ? prod_c - BIAS_TH : prod_c;
    dividend_c = (num_c[19:16] != 4'd0) ? 16'hFFFF : num_c[15:0];

    duty_raw = {1'b0, div_quot} + (bias_q ? 17'd128 : 17'd0);
    if (duty_raw > 17'd255)
      duty_c = '1;
    else if (duty_raw[DUTY_W-1:0] < MIN_DUTY_D)
      duty_c = MIN_DUTY_D;
    else
      duty_c = duty_raw[DUTY_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    pwm_d        = pwm_q;
    dir_d        = dir_q;
    motor_en_d   = motor_en_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    upd_cnt_d    = upd_cnt_q;
    settle_cnt_d = settle_cnt_q;
    bias_d       = bias_q;
    div_start    = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d      = IDLE;
      motor_en_d   = 1'b0;
      pwm_d        = '0;
      upd_cnt_d    = '0;
      settle_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            if (cmd_angle >= CPR_A) begin
              err_d = 1'b1;
            end else begin
              target_d = cmd_angle;
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          if (near_c) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            dir_d     = dir_c;
            div_start = 1'b1;
            bias_d    = bias_c;
            state_d   = DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            pwm_d      = duty_c;
            motor_en_d = 1'b1;
            upd_cnt_d  = '0;
            state_d    = DRIVE;
          end
        end
        DRIVE: begin
          dir_d = dir_c;
          if (near_c) begin
            motor_en_d   = 1'b0;
            pwm_d        = '0;
            settle_cnt_d = '0;
            state_d      = SETTLE;
          end else if (upd_cnt_q == UPDATE_LAST) begin
            div_start = 1'b1;
            bias_d    = bias_c;
            upd_cnt_d = '0;
            state_d   = DIV;
          end else begin
            upd_cnt_d = upd_cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            if (near_c) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = CALC;
            end
          end else begin
            settle_cnt_d = settle_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      pwm_q        <= '0;
      dir_q        <= 1'b1;
      motor_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      upd_cnt_q    <= '0;
      settle_cnt_q <= '0;
      bias_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      pwm_q        <= pwm_d;
      dir_q        <= dir_d;
      motor_en_q   <= motor_en_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      upd_cnt_q    <= upd_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      bias_q       <= bias_d;
    end
  end

  round_div #(
    .DIVIDEND_W(16),
    .DIVISOR_W (ANGLE_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(dividend_c),
    .divisor (DIVISOR),
    .done    (div_done),
    .quotient(div_quot)
  );

  assign cmd_ready = cmd_ready_q;
  assign pwm_duty  = pwm_q;
  assign dir       = dir_q;
  assign motor_en  = motor_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_angle_seek_ctrl.sv
// Directed bench for angle_seek_ctrl: vector table plus hand-timed sequences.
module tb_angle_seek_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_angle;
  logic [11:0] cur_angle;
  logic        abort;
  logic [7:0]  pwm_duty;
  logic        dir;
  logic        motor_en;
  logic        busy;
  logic        done;
  logic        err_range;

  int unsigned checks   = 0;
  int unsigned errors   = 0;
  int unsigned done_cnt = 0;

  typedef struct {
    logic [11:0] tgt;
    logic [11:0] cur;
    logic        go;
    logic        exp_dir;
    logic [7:0]  exp_duty;
  } vec_t;

  vec_t vecs[14];

  angle_seek_ctrl #(
    .COUNTS_PER_REV(1006),
    .TOL           (2),
    .MIN_DUTY      (20),
    .SETTLE_CYC    (50),
    .UPDATE_CYC    (40)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_angle(cmd_angle),
    .cur_angle(cur_angle),
    .abort    (abort),
    .pwm_duty (pwm_duty),
    .dir      (dir),
    .motor_en (motor_en),
    .busy     (busy),
    .done     (done),
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [11:0] ang);
    cmd_angle = ang;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int unsigned d0;

    vecs[0]  = '{12'd978,  12'd28,   1'b1, 1'b0, 8'd28};
    vecs[1]  = '{12'd503,  12'd0,    1'b1, 1'b1, 8'd255};
    vecs[2]  = '{12'd10,   12'd0,    1'b1, 1'b1, 8'd20};
    vecs[3]  = '{12'd1005, 12'd0,    1'b0, 1'b0, 8'd0};
    vecs[4]  = '{12'd0,    12'd500,  1'b1, 1'b0, 8'd253};
    vecs[5]  = '{12'd300,  12'd0,    1'b1, 1'b1, 8'd152};
    vecs[6]  = '{12'd200,  12'd0,    1'b1, 1'b1, 8'd101};
    vecs[7]  = '{12'd100,  12'd1000, 1'b1, 1'b1, 8'd54};
    vecs[8]  = '{12'd3,    12'd0,    1'b1, 1'b1, 8'd20};
    vecs[9]  = '{12'd2,    12'd0,    1'b0, 1'b0, 8'd0};
    vecs[10] = '{12'd1004, 12'd0,    1'b0, 1'b0, 8'd0};
    vecs[11] = '{12'd5,    12'd1003, 1'b1, 1'b1, 8'd20};
    vecs[12] = '{12'd520,  12'd17,   1'b1, 1'b1, 8'd255};
    vecs[13] = '{12'd0,    12'd503,  1'b1, 1'b1, 8'd255};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_angle = '0;
    cur_angle = '0;
    abort     = 1'b0;
    tick(3);
    chk("reset_state", {pwm_duty, dir, motor_en, busy, done, err_range, cmd_ready},
        {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    #3 rst_n = 1'b1;
    tick(2);
    chk("ready_after_reset", {cmd_ready, busy}, {1'b1, 1'b0});

    foreach (vecs[i]) begin
      cur_angle = vecs[i].cur;
      issue(vecs[i].tgt);
      if (vecs[i].go) begin
        tick(17);
        chk($sformatf("v%0d_preload", i), {busy, motor_en, pwm_duty}, {1'b1, 1'b0, 8'd0});
        tick(1);
        chk($sformatf("v%0d_duty", i), pwm_duty, vecs[i].exp_duty);
        chk($sformatf("v%0d_dir", i), dir, vecs[i].exp_dir);
        chk($sformatf("v%0d_motor_en", i), {motor_en, done}, {1'b1, 1'b0});
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk($sformatf("v%0d_abort", i), {busy, motor_en, pwm_duty, cmd_ready},
            {1'b0, 1'b0, 8'd0, 1'b1});
      end else begin
        tick(1);
        chk($sformatf("v%0d_done", i), {done, motor_en, err_range}, {1'b1, 1'b0, 1'b0});
        tick(1);
        chk($sformatf("v%0d_done_clear", i), {done, busy}, {1'b0, 1'b0});
      end
    end

    issue(12'd1006);
    chk("err_range_pulse", {err_range, busy, done}, {1'b1, 1'b0, 1'b0});
    tick(1);
    chk("err_range_clear", {err_range, busy, cmd_ready}, {1'b0, 1'b0, 1'b1});

    // long move: ignored command, duty refresh, settle retry, final done
    cur_angle = 12'd0;
    issue(12'd200);
    tick(18);
    chk("mv_duty", {motor_en, pwm_duty}, {1'b1, 8'd101});
    cur_angle = 12'd150;
    cmd_angle = 12'd10;
    cmd_valid = 1'b1;
    chk("ready_low_busy", cmd_ready, 1'b0);
    tick(1);
    cmd_valid = 1'b0;
    tick(55);
    chk("refresh_hold", {motor_en, dir, pwm_duty}, {1'b1, 1'b1, 8'd101});
    tick(1);
    chk("refresh_duty", {motor_en, pwm_duty}, {1'b1, 8'd25});

    d0 = done_cnt;
    cur_angle = 12'd199;
    tick(1);
    chk("settle_stop", {busy, motor_en, pwm_duty}, {1'b1, 1'b0, 8'd0});
    tick(3);
    cur_angle = 12'd190;
    tick(64);
    chk("retry_div", {busy, motor_en, pwm_duty}, {1'b1, 1'b0, 8'd0});
    tick(1);
    chk("retry_drive", {motor_en, dir, pwm_duty}, {1'b1, 1'b1, 8'd20});
    chk("no_early_done", done_cnt, d0);
    cur_angle = 12'd200;
    tick(50);
    chk("settle_wait", {done, busy, motor_en}, {1'b0, 1'b1, 1'b0});
    tick(1);
    chk("final_done", {done, busy, err_range}, {1'b1, 1'b0, 1'b0});
    tick(1);
    chk("final_done_clear", {done, cmd_ready}, {1'b0, 1'b1});
    chk("single_done", done_cnt, d0 + 1);

    cur_angle = 12'd28;
    d0 = done_cnt;
    issue(12'd978);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_div", {busy, motor_en, pwm_duty, cmd_ready}, {1'b0, 1'b0, 8'd0, 1'b1});
    tick(25);
    chk("abort_div_discard", {busy, motor_en, pwm_duty}, {1'b0, 1'b0, 8'd0});
    chk("abort_div_no_done", done_cnt, d0);

    issue(12'd978);
    tick(18);
    chk("pre_abort_drive", {motor_en, pwm_duty}, {1'b1, 8'd28});
    cur_angle = 12'd978;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_drive", {busy, motor_en, pwm_duty}, {1'b0, 1'b0, 8'd0});
    tick(3);
    chk("abort_wins", done_cnt, d0);

    cur_angle = 12'd28;
    issue(12'd978);
    tick(8);
    rst_n = 1'b0;
    #1;
    chk("rst_div", {busy, motor_en, pwm_duty, dir}, {1'b0, 1'b0, 8'd0, 1'b1});
    #2 rst_n = 1'b1;
    tick(25);
    chk("rst_div_after", {busy, motor_en, pwm_duty, cmd_ready}, {1'b0, 1'b0, 8'd0, 1'b1});

    issue(12'd978);
    tick(18);
    chk("pre_rst_drive", motor_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_drive", {busy, motor_en, pwm_duty, dir}, {1'b0, 1'b0, 8'd0, 1'b1});
    #2 rst_n = 1'b1;
    tick(5);
    chk("rst_drive_after", {busy, motor_en, cmd_ready}, {1'b0, 1'b0, 1'b1});
    chk("rst_no_done", done_cnt, d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
